// File: rtl/clefia_sbox_arb_if.sv
// Request/result/S-box bundle for the shared CLEFIA S-box scheduler.
// The slave side is the scheduler; the master side holds the two
// requesters, the result consumers and the external S0/S1 lookups.
interface clefia_sbox_arb_if;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [31:0] rq_data0;
    logic [31:0] rq_data1;
    logic        rq_fsel0;
    logic        rq_fsel1;
    logic [1:0]  rs_valid;
    logic [1:0]  rs_ready;
    logic [31:0] rs_data0;
    logic [31:0] rs_data1;
    logic [7:0]  sb0_in;
    logic [7:0]  sb1_in;
    logic [7:0]  sb0_out;
    logic [7:0]  sb1_out;

    modport slave (
        input  rq_valid, rq_data0, rq_data1, rq_fsel0, rq_fsel1,
        input  rs_ready, sb0_out, sb1_out,
        output rq_ready, rs_valid, rs_data0, rs_data1, sb0_in, sb1_in
    );

    modport master (
        output rq_valid, rq_data0, rq_data1, rq_fsel0, rq_fsel1,
        output rs_ready, sb0_out, sb1_out,
        input  rq_ready, rs_valid, rs_data0, rs_data1, sb0_in, sb1_in
    );
endinterface

// File: rtl/clefia_sbox_arb.sv
// Time-multiplexes one S0 and one S1 lookup between two 32-bit requesters.
// Each word takes two lookup cycles (HI: bytes 0-1, LO: bytes 2-3); a new
// grant may land in the LO cycle so back-to-back words issue every 2 cycles.
module clefia_sbox_arb (
    input  logic             clk,
    input  logic             rst,
    clefia_sbox_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        ptr_reg;
    logic [31:0] op_data_reg;
    logic        op_fsel_reg;
    logic        op_owner_reg;
    logic [15:0] hi_bytes_reg;

    logic [31:0] rq_data [2];
    logic [1:0]  rq_fsel;
    logic [1:0]  elig;
    logic [1:0]  slot_valid;
    logic [31:0] slot_data [2];
    logic        arb_open;
    logic        grant_any;
    logic        grant_port;
    logic [7:0]  byte_a;
    logic [7:0]  byte_b;
    logic [7:0]  res_a;
    logic [7:0]  res_b;

    assign rq_data[0] = bus.rq_data0;
    assign rq_data[1] = bus.rq_data1;
    assign rq_fsel    = {bus.rq_fsel1, bus.rq_fsel0};

    // Arbitration is only possible when no word is in flight or the
    // in-flight word is in its last lookup cycle.
    assign arb_open   = (state_reg == IDLE) || (state_reg == LO);
    assign grant_any  = !rst && arb_open && (|elig);
    assign grant_port = (&elig) ? ptr_reg : elig[1];

    assign bus.rq_ready = grant_any ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

    // Byte pair for this lookup cycle; fsel swaps which S-box sees which byte.
    always_comb begin
        byte_a = 8'h00;
        byte_b = 8'h00;
        if (!rst) begin
            case (state_reg)
                HI: begin
                    byte_a = op_data_reg[31:24];
                    byte_b = op_data_reg[23:16];
                end
                LO: begin
                    byte_a = op_data_reg[15:8];
                    byte_b = op_data_reg[7:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.sb0_in = op_fsel_reg ? byte_b : byte_a;
    assign bus.sb1_in = op_fsel_reg ? byte_a : byte_b;
    assign res_a      = op_fsel_reg ? bus.sb1_out : bus.sb0_out;
    assign res_b      = op_fsel_reg ? bus.sb0_out : bus.sb1_out;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next state: a grant always starts HI; LO falls back to IDLE without one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = grant_any ? HI : IDLE;
            HI:      state_next = LO;
            LO:      state_next = grant_any ? HI : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation capture on grant, round-robin pointer, and HI result bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= 1'b0;
            op_data_reg  <= 32'h0;
            op_fsel_reg  <= 1'b0;
            op_owner_reg <= 1'b0;
            hi_bytes_reg <= 16'h0;
        end else begin
            if (grant_any) begin
                op_data_reg  <= rq_data[grant_port];
                op_fsel_reg  <= rq_fsel[grant_port];
                op_owner_reg <= grant_port;
                ptr_reg      <= ~grant_port;
            end
            if (state_reg == HI) begin
                hi_bytes_reg <= {res_a, res_b};
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic        valid_reg;
        logic [31:0] data_reg;

        assign elig[gi] = bus.rq_valid[gi] && !valid_reg &&
                          !((state_reg != IDLE) && (op_owner_reg == 1'(gi)));

        // Result slot: filled at the owner's LO edge, emptied when consumed.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                data_reg  <= 32'h0;
            end else if ((state_reg == LO) && (op_owner_reg == 1'(gi))) begin
                valid_reg <= 1'b1;
                data_reg  <= {hi_bytes_reg, res_a, res_b};
            end else if (bus.rs_ready[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign slot_valid[gi] = valid_reg;
        assign slot_data[gi]  = data_reg;
    end

    assign bus.rs_valid = slot_valid;
    assign bus.rs_data0 = slot_data[0];
    assign bus.rs_data1 = slot_data[1];
endmodule

// File: tb/tb_clefia_sbox_arb.sv
// Bench for clefia_sbox_arb: directed scenarios plus random traffic, all
// compared against a timestamp-based scheduler model and a word-level
// substitution function.
module tb_clefia_sbox_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clefia_sbox_arb_if bus ();

    clefia_sbox_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Stand-in S-boxes; they agree with CLEFIA at S0(00), S1(00), S0(10)
    // and differ from each other elsewhere.
    function automatic logic [7:0] s0_ref(input logic [7:0] x);
        logic [7:0] t;
        if (x == 8'h00) return 8'h57;
        if (x == 8'h10) return 8'h28;
        t = x * 8'd29;
        return (t ^ 8'h5a) + 8'd3;
    endfunction

    function automatic logic [7:0] s1_ref(input logic [7:0] x);
        logic [7:0] t;
        if (x == 8'h00) return 8'h6c;
        t = (x ^ 8'hc3) * 8'd37;
        return t + 8'd11;
    endfunction

    assign bus.sb0_out = s0_ref(bus.sb0_in);
    assign bus.sb1_out = s1_ref(bus.sb1_in);

    // Whole-word substitution: F0 uses S0,S1,S0,S1 on bytes 0..3, F1 the reverse.
    function automatic logic [31:0] subst(input logic [31:0] t, input logic fsel);
        logic [31:0] w;
        logic [7:0]  b;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            b = t[31-8*k -: 8];
            w[31-8*k -: 8] = ((((k % 2) == 0) ? 1'b1 : 1'b0) ^ fsel) ? s0_ref(b) : s1_ref(b);
        end
        return w;
    endfunction

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc     = 0;
    int          m_last  = -100;
    logic        m_owner = 1'b0;
    logic        m_fsel  = 1'b0;
    logic        m_ptr   = 1'b0;
    logic [31:0] m_t     = 32'h0;
    logic [1:0]  m_slot_v = 2'b00;
    logic [31:0] m_slot_d [2] = '{32'h0, 32'h0};
    logic [1:0]  last_grant = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then
    // advance the model at the rising edge.
    task automatic step();
        int          d;
        logic [1:0]  elig;
        logic [1:0]  g;
        logic [1:0]  rdy;
        logic [31:0] dat [2];
        logic [1:0]  fs;
        logic [7:0]  ba, bb, e0, e1;
        logic [31:0] tw;
        @(negedge clk);
        d      = cyc - m_last;
        rdy    = bus.rs_ready;
        dat[0] = bus.rq_data0;
        dat[1] = bus.rq_data1;
        fs     = {bus.rq_fsel1, bus.rq_fsel0};
        for (int i = 0; i < 2; i++)
            elig[i] = bus.rq_valid[i] && !m_slot_v[i] &&
                      !((d == 1 || d == 2) && (m_owner == 1'(i)));
        g = 2'b00;
        if (!rst && d != 1) begin
            if (elig == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
            else               g = elig;
        end
        e0 = 8'h00;
        e1 = 8'h00;
        if (!rst && (d == 1 || d == 2)) begin
            tw = (d == 1) ? m_t : (m_t << 16);
            ba = tw[31:24];
            bb = tw[23:16];
            e0 = m_fsel ? bb : ba;
            e1 = m_fsel ? ba : bb;
        end
        check_eq("rq_ready", 32'(bus.rq_ready), 32'(g));
        check_eq("rs_valid", 32'(bus.rs_valid), 32'(m_slot_v));
        check_eq("rs_data0", bus.rs_data0, m_slot_d[0]);
        check_eq("rs_data1", bus.rs_data1, m_slot_d[1]);
        check_eq("sb0_in", 32'(bus.sb0_in), 32'(e0));
        check_eq("sb1_in", 32'(bus.sb1_in), 32'(e1));
        last_grant = g;
        @(posedge clk);
        if (rst) begin
            m_last   = -100;
            m_ptr    = 1'b0;
            m_slot_v = 2'b00;
            m_slot_d[0] = 32'h0;
            m_slot_d[1] = 32'h0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (m_slot_v[i] && rdy[i]) m_slot_v[i] = 1'b0;
            if (d == 2) begin
                m_slot_v[m_owner] = 1'b1;
                m_slot_d[m_owner] = subst(m_t, m_fsel);
            end
            if (g != 2'b00) begin
                m_last  = cyc;
                m_owner = g[1];
                m_t     = dat[g[1]];
                m_fsel  = fs[g[1]];
                m_ptr   = ~g[1];
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] r);
        bus.rq_valid = v;
        bus.rs_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rq_valid = 2'b11;
        bus.rs_ready = 2'b00;
        bus.rq_data0 = 32'h0;
        bus.rq_data1 = 32'h0;
        bus.rq_fsel0 = 1'b0;
        bus.rq_fsel1 = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with both requesters valid: no grant, outputs cleared.
        step();
        rst = 1'b0;

        // Basic F0 path on port 0.
        drive(2'b01, 2'b00);
        bus.rq_data0 = 32'h0000_0000;
        bus.rq_fsel0 = 1'b0;
        #1;
        check_eq("f0_grant", 32'(bus.rq_ready), 32'h1);
        step();
        drive(2'b00, 2'b00);
        step();
        step();
        check_eq("f0_valid", 32'(bus.rs_valid), 32'h1);
        check_eq("f0_word", bus.rs_data0, 32'h576c576c);
        drive(2'b00, 2'b01);
        step();

        // Basic F1 path on port 1.
        drive(2'b10, 2'b00);
        bus.rq_data1 = 32'h0000_0000;
        bus.rq_fsel1 = 1'b1;
        step();
        drive(2'b00, 2'b00);
        step();
        step();
        check_eq("f1_word", bus.rs_data1, 32'h6c576c57);
        drive(2'b00, 2'b10);
        step();

        // Byte routing with F1 mapping on port 0.
        drive(2'b01, 2'b00);
        bus.rq_data0 = 32'h0010_0100;
        bus.rq_fsel0 = 1'b1;
        step();
        drive(2'b00, 2'b00);
        check_eq("route_hi_sb0", 32'(bus.sb0_in), 32'h10);
        step();
        check_eq("route_lo_sb0", 32'(bus.sb0_in), 32'h00);
        step();
        check_eq("route_byte1", 32'(bus.rs_data0[23:16]), 32'h28);
        drive(2'b00, 2'b01);
        step();

        // Contention from reset: grants alternate 0,1,0,... every 2 cycles.
        do_reset();
        bus.rq_data0 = 32'h1234_5678;
        bus.rq_data1 = 32'h9abc_def0;
        bus.rq_fsel0 = 1'b0;
        bus.rq_fsel1 = 1'b1;
        drive(2'b11, 2'b11);
        for (int i = 0; i < 12; i++) step();

        // Backpressure on port 0, then release.
        drive(2'b11, 2'b10);
        for (int i = 0; i < 14; i++) step();
        drive(2'b11, 2'b11);
        for (int i = 0; i < 6; i++) step();

        // Reset during HI: no result, pointer back to port 0, full latency.
        drive(2'b00, 2'b11);
        do_reset();
        drive(2'b11, 2'b00);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(2'b11, 2'b00);
        #1;
        check_eq("post_reset_grant", 32'(bus.rq_ready), 32'h1);
        step();
        drive(2'b00, 2'b00);
        check_eq("post_reset_no_valid", 32'(bus.rs_valid), 32'h0);
        step();
        step();
        check_eq("post_reset_latency", 32'(bus.rs_valid), 32'h1);
        drive(2'b00, 2'b11);
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.rq_valid = {($urandom % 4) != 0, ($urandom % 4) != 0};
            bus.rs_ready = {($urandom % 5) < 3, ($urandom % 5) < 3};
            bus.rq_data0 = $urandom;
            bus.rq_data1 = $urandom;
            bus.rq_fsel0 = 1'($urandom % 2);
            bus.rq_fsel1 = 1'($urandom % 2);
            rst = (($urandom % 80) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
